// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues in-order word fetches, buffers tagged
// responses in a DEPTH-entry queue and hands the head to decode.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            i_reset,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_mem_req_valid,
  output logic [XLEN-1:0] o_mem_req_addr,
  input  logic            i_mem_req_ready,
  input  logic            i_mem_rsp_valid,
  input  logic [ILEN-1:0] i_mem_rsp_data,
  output logic            o_instr_valid,
  output logic [ILEN-1:0] o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  input  logic            i_instr_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 2;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [ILEN-1:0] fifo_instr [DEPTH];
  logic [XLEN-1:0] fifo_pc    [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;

  logic [SW-1:0]   credit_used;
  logic [CW-1:0]   in_flight;
  logic [CW-1:0]   discard_on_redirect;
  logic [XLEN-1:0] redirect_target;
  logic            req_fire;
  logic            rsp_drop;
  logic            rsp_push;
  logic            pop;

  // Credit: every slot is reserved at request time, so responses never overflow.
  assign credit_used     = SW'(count) + SW'(outstanding) + SW'(discard);
  assign o_mem_req_valid = !i_reset && !i_redirect && (credit_used < SW'(DEPTH));
  assign o_mem_req_addr  = fetch_pc;
  assign req_fire        = o_mem_req_valid && i_mem_req_ready;

  assign rsp_drop = i_mem_rsp_valid && (discard != '0);
  assign rsp_push = i_mem_rsp_valid && (discard == '0) && (outstanding != '0);

  assign o_instr_valid = (count != '0);
  assign o_instr       = fifo_instr[head];
  assign o_instr_pc    = fifo_pc[head];
  assign pop           = o_instr_valid && i_instr_ready;

  // On redirect, everything still owed by memory becomes garbage; a response
  // landing in the redirect cycle itself is one of them and is already gone.
  assign redirect_target     = {i_redirect_pc[XLEN-1:2], 2'b00};
  assign in_flight           = discard + outstanding;
  assign discard_on_redirect = in_flight - CW'(i_mem_rsp_valid && (in_flight != '0));

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (i_redirect) begin
      fetch_pc    <= redirect_target;
      rsp_pc      <= redirect_target;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= discard_on_redirect;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (rsp_drop) begin
        discard <= discard - CW'(1);
      end
      if (rsp_push) begin
        rsp_pc <= rsp_pc + XLEN'(4);
        tail   <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_push);
      count       <= count + CW'(rsp_push) - CW'(pop);
    end
  end

  // Queue storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (rsp_push && !i_redirect) begin
      fifo_instr[tail] <= i_mem_rsp_data;
      fifo_pc[tail]    <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written redirect/wrap
// sequences, then randomized two-sided stalls against a queue-level model.
module tb_fetch_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            i_reset;
  logic            i_redirect;
  logic [XLEN-1:0] i_redirect_pc;
  logic            o_mem_req_valid;
  logic [XLEN-1:0] o_mem_req_addr;
  logic            i_mem_req_ready;
  logic            i_mem_rsp_valid;
  logic [ILEN-1:0] i_mem_rsp_data;
  logic            o_instr_valid;
  logic [ILEN-1:0] o_instr;
  logic [XLEN-1:0] o_instr_pc;
  logic            i_instr_ready;

  fetch_queue #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0100)
  ) dut (
    .clk(clk), .i_reset(i_reset),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_mem_req_valid(o_mem_req_valid), .o_mem_req_addr(o_mem_req_addr),
    .i_mem_req_ready(i_mem_req_ready),
    .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_data(i_mem_rsp_data),
    .o_instr_valid(o_instr_valid), .o_instr(o_instr), .o_instr_pc(o_instr_pc),
    .i_instr_ready(i_instr_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        redirect;
    logic [31:0] rpc;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_addr;
    logic        instr_ready;
    logic        exp_req_valid;
    logic [31:0] exp_addr;
    logic        exp_ival;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    bit          stale;
    int          cyc;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  function automatic logic [31:0] mem_data(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_0f0f;
  endfunction

  function automatic vec_t mk(logic rd, logic [31:0] rpc, logic rr, logic rv,
                              logic [31:0] ra, logic ir, logic ev,
                              logic [31:0] ea, logic ei, logic [31:0] ep);
    vec_t v;
    v.redirect = rd; v.rpc = rpc; v.req_ready = rr; v.rsp_valid = rv;
    v.rsp_addr = ra; v.instr_ready = ir; v.exp_req_valid = ev;
    v.exp_addr = ea; v.exp_ival = ei; v.exp_pc = ep;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_redirect = 1'b0; i_redirect_pc = '0; i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b0; i_mem_rsp_data = '0; i_instr_ready = 1'b0;
  endtask

  // Drive one cycle of inputs at negedge and check outputs before the next posedge.
  task automatic apply(vec_t v);
    @(negedge clk);
    i_redirect      = v.redirect;
    i_redirect_pc   = v.rpc;
    i_mem_req_ready = v.req_ready;
    i_mem_rsp_valid = v.rsp_valid;
    i_mem_rsp_data  = v.rsp_valid ? mem_data(v.rsp_addr) : '0;
    i_instr_ready   = v.instr_ready;
    #1;
    chk("req_valid", 64'(o_mem_req_valid), 64'(v.exp_req_valid));
    chk("req_addr", 64'(o_mem_req_addr), 64'(v.exp_addr));
    chk("instr_valid", 64'(o_instr_valid), 64'(v.exp_ival));
    if (v.exp_ival) begin
      chk("instr_pc", 64'(o_instr_pc), 64'(v.exp_pc));
      chk("instr", 64'(o_instr), 64'(mem_data(v.exp_pc)));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b1;
    idle_inputs();
    i_mem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", 64'(o_mem_req_valid), 64'd0);
    chk("rst_instr_valid", 64'(o_instr_valid), 64'd0);
    chk("rst_req_addr", 64'(o_mem_req_addr), 64'h100);
    i_reset = 1'b0;
    idle_inputs();
  endtask

  vec_t vecs[$];
  req_t inflight[$];
  ent_t fifo_q[$];

  initial begin
    i_reset = 1'b1;
    idle_inputs();

    // Fill to DEPTH under decode stall, drain, resume, then redirect to 0x2002.
    //          rd rpc          rr rv rsp_addr     ir ev ea           ei ep
    vecs.push_back(mk(0, 0,           1, 0, 0,           0, 1, 32'h100,  0, 0));
    vecs.push_back(mk(0, 0,           1, 1, 32'h100,     0, 1, 32'h104,  0, 0));
    vecs.push_back(mk(0, 0,           1, 1, 32'h104,     0, 1, 32'h108,  1, 32'h100));
    vecs.push_back(mk(0, 0,           1, 1, 32'h108,     0, 1, 32'h10c,  1, 32'h100));
    vecs.push_back(mk(0, 0,           1, 1, 32'h10c,     0, 0, 32'h110,  1, 32'h100));
    vecs.push_back(mk(0, 0,           1, 0, 0,           0, 0, 32'h110,  1, 32'h100));
    vecs.push_back(mk(0, 0,           1, 0, 0,           1, 0, 32'h110,  1, 32'h100));
    vecs.push_back(mk(0, 0,           1, 0, 0,           0, 1, 32'h110,  1, 32'h104));
    vecs.push_back(mk(0, 0,           1, 1, 32'h110,     1, 0, 32'h114,  1, 32'h104));
    vecs.push_back(mk(0, 0,           1, 0, 0,           1, 1, 32'h114,  1, 32'h108));
    vecs.push_back(mk(0, 0,           1, 0, 0,           1, 1, 32'h118,  1, 32'h10c));
    vecs.push_back(mk(1, 32'h2002,    1, 0, 0,           1, 0, 32'h11c,  1, 32'h110));
    vecs.push_back(mk(0, 0,           0, 1, 32'h114,     0, 1, 32'h2000, 0, 0));
    vecs.push_back(mk(0, 0,           1, 1, 32'h118,     0, 1, 32'h2000, 0, 0));
    vecs.push_back(mk(0, 0,           0, 1, 32'h2000,    0, 1, 32'h2004, 0, 0));
    vecs.push_back(mk(0, 0,           0, 0, 0,           0, 1, 32'h2004, 1, 32'h2000));

    do_reset();
    foreach (vecs[i]) apply(vecs[i]);

    // PC wrap at the top of the address space.
    apply(mk(1, 32'hffff_fffe, 0, 0, 0,            0, 0, 32'h2004,      1, 32'h2000));
    apply(mk(0, 0,             1, 0, 0,            0, 1, 32'hffff_fffc, 0, 0));
    apply(mk(0, 0,             1, 1, 32'hffff_fffc, 0, 1, 32'h0,        0, 0));
    apply(mk(0, 0,             0, 1, 32'h0,        1, 1, 32'h4,         1, 32'hffff_fffc));
    apply(mk(0, 0,             0, 0, 0,            1, 1, 32'h4,         1, 32'h0));
    apply(mk(0, 0,             0, 0, 0,            0, 1, 32'h4,         0, 0));

    // Redirect coinciding with a response and a pop.
    apply(mk(0, 0,        1, 0, 0,      0, 1, 32'h4,    0, 0));
    apply(mk(0, 0,        1, 1, 32'h4,  0, 1, 32'h8,    0, 0));
    apply(mk(0, 0,        1, 0, 0,      0, 1, 32'hc,    1, 32'h4));
    apply(mk(1, 32'h3000, 1, 1, 32'h8,  1, 0, 32'h10,   1, 32'h4));
    apply(mk(0, 0,        0, 0, 0,      0, 1, 32'h3000, 0, 0));
    chk("discard_after_redirect", 64'(dut.discard), 64'd1);
    apply(mk(0, 0,        1, 1, 32'hc,  0, 1, 32'h3000, 0, 0));
    apply(mk(0, 0,        0, 1, 32'h3000, 0, 1, 32'h3004, 0, 0));
    apply(mk(0, 0,        0, 0, 0,      0, 1, 32'h3004, 1, 32'h3000));

    // Randomized two-sided stalls and redirects against the queue model.
    do_reset();
    begin
      logic [31:0] m_fpc;
      bit          exp_rv;
      bit          fire;
      bit          popped;
      req_t        r;
      ent_t        e;
      m_fpc = 32'h100;
      for (int cyc = 0; cyc < 10000 && n_bad < 100; cyc++) begin
        @(negedge clk);
        i_redirect      = ($urandom_range(99) < 3);
        i_redirect_pc   = ($urandom_range(2) == 0) ? (32'hffff_fff0 | ($urandom & 32'hf))
                                                   : $urandom;
        i_mem_req_ready = ($urandom_range(9) < 6);
        i_instr_ready   = ($urandom_range(9) < 6);
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_data  = '0;
        if (inflight.size() > 0 && inflight[0].cyc < cyc && $urandom_range(1) == 1) begin
          i_mem_rsp_valid = 1'b1;
          i_mem_rsp_data  = inflight[0].data;
        end
        #1;
        exp_rv = !i_redirect && (fifo_q.size() + inflight.size() < DEPTH);
        chk("rnd_req_valid", 64'(o_mem_req_valid), 64'(exp_rv));
        if (exp_rv) chk("rnd_req_addr", 64'(o_mem_req_addr), 64'(m_fpc));
        chk("rnd_instr_valid", 64'(o_instr_valid), 64'(fifo_q.size() != 0));
        if (fifo_q.size() != 0) begin
          chk("rnd_instr_pc", 64'(o_instr_pc), 64'(fifo_q[0].pc));
          chk("rnd_instr", 64'(o_instr), 64'(fifo_q[0].instr));
        end
        chk("rnd_credit", 64'(int'(dut.count) + int'(dut.outstanding) + int'(dut.discard) <= DEPTH), 64'd1);
        if (i_mem_rsp_valid)
          chk("rnd_rsp_expected", 64'((dut.outstanding != 0) || (dut.discard != 0)), 64'd1);

        fire   = o_mem_req_valid && i_mem_req_ready;
        popped = o_instr_valid && i_instr_ready;
        if (!i_redirect && popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (i_mem_rsp_valid) begin
          r = inflight.pop_front();
          if (!r.stale && !i_redirect) begin
            e.instr = r.data; e.pc = r.pc;
            fifo_q.push_back(e);
          end
        end
        if (i_redirect) begin
          foreach (inflight[k]) inflight[k].stale = 1'b1;
          fifo_q.delete();
          m_fpc = {i_redirect_pc[31:2], 2'b00};
        end else if (fire) begin
          r.pc = m_fpc; r.data = mem_data(o_mem_req_addr); r.stale = 1'b0; r.cyc = cyc;
          inflight.push_back(r);
          m_fpc = m_fpc + 32'd4;
        end
      end
    end

    idle_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end.
- Owns the fetch PC and issues pipelined, in-order word requests to instruction memory over a valid/ready request channel.
- Buffers returned instructions, tagged with their PC, in a DEPTH-entry FIFO.
- Presents the FIFO head to decode with a valid/ready handshake.
- Branch/jump redirects flush the queue and discard every in-flight response.

Parameters:
XLEN, 32, address/PC width in bits
ILEN, 32, instruction word width in bits
DEPTH, 4, instruction queue entries; power of two, >= 2
RESET_PC, 0, fetch PC value after reset

Ports:
clk  input  1  clock, rising edge
i_reset  input  1  asynchronous, active-high reset
i_redirect  input  1  redirect request (branch taken / jump / trap), single-cycle pulse
i_redirect_pc  input  XLEN  redirect target; bits [1:0] ignored and treated as 0
o_mem_req_valid  output  1  fetch request valid
o_mem_req_addr  output  XLEN  fetch request word address
i_mem_req_ready  input  1  memory accepts request
i_mem_rsp_valid  input  1  response valid; responses return in request order, latency >= 1 cycle
i_mem_rsp_data  input  ILEN  response instruction word
o_instr_valid  output  1  queue head valid
o_instr  output  ILEN  queue head instruction
o_instr_pc  output  XLEN  PC of queue head
i_instr_ready  input  1  decode consumes head

Behaviour:
- State: fetch_pc, rsp_pc (PC of next expected response), FIFO storage {instr, pc} with head/tail pointers, count, outstanding, discard. Counters are $clog2(DEPTH)+1 bits wide.
- Reset (async): fetch_pc = rsp_pc = RESET_PC; count = outstanding = discard = 0.
  - o_mem_req_valid = 0 and o_instr_valid = 0 while i_reset is high.
  - o_mem_req_addr = RESET_PC.
  - o_instr/o_instr_pc values are don't-care while invalid.
- Request issue:
  - o_mem_req_valid = !i_reset && !i_redirect && (count + outstanding + discard) < DEPTH. This credit rule guarantees every accepted response has a free slot.
  - o_mem_req_addr = fetch_pc.
  - Handshake (valid && ready): fetch_pc += 4 (mod 2^XLEN, wraps silently); outstanding += 1.
  - Address is stable while valid && !ready, except on redirect.
- Response:
  - Any i_mem_rsp_valid while discard > 0: word dropped, discard -= 1.
  - Otherwise, any i_mem_rsp_valid: outstanding -= 1; {data, rsp_pc} written at tail; rsp_pc += 4; count += 1.
  - Response with outstanding == discard == 0: protocol error; ignored, flagged by bench assertion.
- Output:
  - o_instr_valid = (count != 0); o_instr/o_instr_pc driven from the head entry.
  - Pop on o_instr_valid && i_instr_ready.
  - Latency: response in cycle N appears at the head no earlier than N+1. There is no response-to-output bypass.
  - Simultaneous push and pop: count unchanged; both pointers advance; pointers wrap modulo DEPTH.
- Redirect (cycle R, i_redirect = 1):
  - No request is issued in cycle R.
  - FIFO flushed: count = 0; pointers reset. A pop in cycle R is ignored.
  - fetch_pc = rsp_pc = {i_redirect_pc[XLEN-1:2], 2'b00}.
  - discard = discard + outstanding minus 1 if a response arrives in cycle R (that response is dropped); outstanding = 0.
  - First request to the target is issued in R+1 if credit permits.
- Back-to-back redirects: the latest target wins; discard accumulates correctly.
- Memory stall (ready low): fetch_pc holds; queue drains normally.
- Decode stall (ready low): queue fills to DEPTH; requests stop once count + outstanding + discard == DEPTH.

Test Plan:
- Reset release with 1-cycle memory latency, decode always ready, RESET_PC=0x100:
  - Expected: requests 0x100, 0x104, 0x108...
  - First o_instr_valid two cycles after the first handshake; o_instr_pc tracks 0x100, 0x104... and matches data.
- Decode ready held low, memory always ready:
  - Expected: exactly 4 requests issued (DEPTH=4), o_mem_req_valid drops.
  - Raise ready: head pops 0x100 first; issue resumes one entry per pop.
- Redirect to 0x2002 with 2 requests in flight:
  - Expected: both late responses dropped; queue empty in R+1.
  - Next request addr 0x2000; first o_instr_pc = 0x2000.
- Redirect in the same cycle as a response and a pop:
  - Expected: response dropped, pop ignored, discard = outstanding-1, no stale PC reaches decode.
- fetch_pc = 0xFFFFFFFC, XLEN=32:
  - Expected: next request addr 0x00000000; o_instr_pc wraps identically.
- Random ready/valid stalls on both sides, 10k cycles:
  - Scoreboard checks PC-ordered, gap-free instruction stream.
  - count + outstanding + discard <= DEPTH holds every cycle.
